display_num: RTL
================

DISPLAY_NUM -- requirements
Module: display_num

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, binary input width in bits (1..32).
REQ-002 The module SHALL have parameter DIGITS, default 5, number of decimal digits driven; legal only if 10^DIGITS > 2^WIDTH-1, with elaboration failing otherwise.
REQ-003 The module SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: conversion request, sampled on the rising edge of clock.
REQ-006 The module SHALL have port binary, input, WIDTH bits: unsigned value to display, captured when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse when seg is updated.
REQ-009 The module SHALL have port seg, output, 7*DIGITS bits: seg[7i+6:7i] drives digit i (i=0 units), bit order g..a, active-low, registered.

Function
REQ-010 The module SHALL implement FSM states IDLE, CONVERT and UPDATE.
REQ-011 In IDLE with start=1, the module SHALL capture binary into a shift register, clear all BCD nibbles, clear the iteration counter, set busy=1 and enter CONVERT.
REQ-012 In CONVERT, each cycle the module SHALL add 3 to every BCD nibble >= 5, then shift {BCD, shift register} left by one bit (double-dabble).
REQ-013 After exactly WIDTH CONVERT cycles, the module SHALL enter UPDATE.
REQ-014 In UPDATE, the module SHALL load seg from the BCD nibbles, assert done for that cycle, deassert busy on the next edge and return to IDLE.
REQ-015 Latency SHALL be fixed: with start accepted at edge 0, seg and done SHALL change at edge WIDTH+1.
REQ-016 Digit encodings (hex, gfedcba, active-low) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10; the blank pattern SHALL be 7F.
REQ-017 start SHALL be ignored in CONVERT and UPDATE: no restart, and captured data SHALL be unchanged.
REQ-018 seg SHALL hold its previous value during CONVERT, with no intermediate values visible.
REQ-019 Changes on binary after capture SHALL have no effect on the conversion in progress.
REQ-020 For a nibble value > 9 (unreachable by construction), the module SHALL output 7F.

Reset
REQ-021 reset=0 SHALL asynchronously force: state IDLE, busy=0, done=0, every seg digit=7F, shift register, BCD and counter=0.
REQ-022 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; seg SHALL remain 7F until the next completed conversion.
REQ-023 The first start after reset release SHALL be accepted on the first rising edge with reset=1.

Configuration
REQ-024 With macro DISPLAY_NUM_BLANK_EN defined, the module SHALL drive 7F on every digit above the most significant nonzero digit at UPDATE; digit 0 SHALL always be shown, so value 0 displays a single "0".
REQ-025 Without DISPLAY_NUM_BLANK_EN, the module SHALL show all DIGITS digits, including leading zeros.

Verification
REQ-026 The bench SHALL cover: WIDTH=16, DIGITS=5, binary=1234, start pulse -> done at edge 17; seg digits 4..0 = 40,79,24,30,19 (blank off), or 7F,79,24,30,19 (blank on).
REQ-027 The bench SHALL cover: binary=65535 -> digits 6,5,5,3,5 = 02,12,12,30,12; binary=0 -> all 40 (blank off), or 7F,7F,7F,7F,40 (blank on).
REQ-028 The bench SHALL cover: start held high for 40 cycles with binary changing every cycle -> done pulses at edges 17, 35 (next acceptance at edge 18); each displayed value equals binary at its acceptance edge.
REQ-029 The bench SHALL cover: reset low at edge 8 of a conversion -> busy=0 immediately, no done, seg all 7F; a new start of 42 -> digits 0,0,0,4,2 after 17 edges.
REQ-030 The bench SHALL cover: WIDTH=8, DIGITS=3, binary=255 -> done at edge 9, digits 2,5,5 = 24,12,12.
REQ-031 The bench SHALL cover: start pulse during the UPDATE cycle -> ignored; busy=0 on the following cycle, no second done.

Source files
------------

// File: rtl/display_num.sv
// Binary to seven-segment decimal display driver using a double-dabble converter.
// Optional leading-zero blanking when DISPLAY_NUM_BLANK_EN is defined.
module display_num #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int unsigned BCDW = 4 * DIGITS;
    localparam int unsigned SEGW = 7 * DIGITS;
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_legal();
        longint unsigned lim;
        longint unsigned p;
        lim = (64'd1 << WIDTH) - 64'd1;
        p   = 64'd1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (p <= lim) p = p * 64'd10;
        end
        return p > lim;
    endfunction

    if (!digits_legal()) begin : g_bad_digits
        $error("display_num: DIGITS too small for WIDTH");
    end

    function automatic logic [6:0] seg_enc(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BCDW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SEGW-1:0]   seg_q, seg_d, seg_new;
`ifdef DISPLAY_NUM_BLANK_EN
    logic              seen;
`endif

    // Next-state, datapath and output logic.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        seg_d   = seg_q;
        bcd_adj = bcd_q;
        seg_new = '1;
`ifdef DISPLAY_NUM_BLANK_EN
        seen    = 1'b0;
`endif

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            seg_new[7*i +: 7] = seg_enc(bcd_q[4*i +: 4]);
        end

`ifdef DISPLAY_NUM_BLANK_EN
        // Blank every digit above the most significant nonzero one; digit 0 always shows.
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) seen = 1'b1;
            if (!seen) seg_new[7*i +: 7] = 7'h7F;
        end
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = binary;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                seg_d   = seg_new;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg  = seg_q;

endmodule
